// File: rtl/dmem_responder.sv
// Word-organised data RAM responder for the core data-memory port: byte-lane writes,
// programmable wait states, single-cycle mem_ready pulse and out-of-range flagging.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_a,
   input  logic [31:0] mem_wd,
   input  logic [3:0]  mem_wmask,
   output logic [31:0] mem_rd,
   output logic        mem_ready,
   output logic        mem_err,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Handshake: the core raises mem_req and holds it until mem_ready; the request is
   // sampled only in IDLE, mem_ready/mem_err are high for exactly the RESP cycle, and an
   // IDLE cycle always separates two transactions.

   logic [1:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             we_q, we_d;
   logic             in_range_q, in_range_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      wd_q, wd_d;
   logic [3:0]       wmask_q, wmask_d;
   logic [31:0]      rd_q, rd_d;

   logic [31:0]      ram_q [DEPTH_WORDS];

   logic [31:0]      byte_off;
   logic [31:0]      word_off;
   logic             req_in_range;
   logic [IDX_W-1:0] req_idx;

   // Below-base addresses wrap to a huge offset, so the explicit >= check is still needed.
   assign byte_off     = mem_a - BASE_ADDR;
   assign word_off     = byte_off >> 2;
   assign req_in_range = (mem_a >= BASE_ADDR) && (word_off < 32'(DEPTH_WORDS));
   assign req_idx      = word_off[IDX_W-1:0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      in_range_d = in_range_q;
      idx_d      = idx_q;
      wd_d       = wd_q;
      wmask_d    = wmask_q;
      rd_d       = rd_q;

      case (state_q)
         S_IDLE: begin
            if (mem_req) begin
               we_d       = mem_we;
               in_range_d = req_in_range;
               idx_d      = req_idx;
               wd_d       = mem_wd;
               wmask_d    = mem_wmask;
               cnt_d      = WAIT_CNT;
               state_d    = (WAIT_CNT == 4'd0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The _d copies already hold the live request when WAIT_STATES is zero.
      if ((state_d == S_RESP) && (state_q != S_RESP) && !we_d) begin
         rd_d = in_range_d ? ram_q[idx_d] : 32'h0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         we_q       <= 1'b0;
         in_range_q <= 1'b0;
         idx_q      <= '0;
         wd_q       <= 32'h0;
         wmask_q    <= 4'h0;
         rd_q       <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         in_range_q <= in_range_d;
         idx_q      <= idx_d;
         wd_q       <= wd_d;
         wmask_q    <= wmask_d;
         rd_q       <= rd_d;
      end
   end

   // Array is not reset; an async reset forces IDLE, which drops a pending write.
   always_ff @(posedge clk) begin
      if ((state_q == S_RESP) && we_q && in_range_q) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask_q[i]) begin
               ram_q[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
            end
         end
      end
   end

   assign mem_rd    = rd_q;
   assign mem_ready = (state_q == S_RESP);
   assign mem_err   = (state_q == S_RESP) && !in_range_q;
   assign busy      = (state_q == S_WAIT) || (state_q == S_RESP);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three builds (1, 0 and 3 wait states) sharing one clock,
// table-driven accesses, a randomised byte-lane model and hand-written corner sequences.
module tb_dmem_responder;

   logic        clk;
   logic        rst  [3];
   logic        req  [3];
   logic        we   [3];
   logic [31:0] a    [3];
   logic [31:0] wd   [3];
   logic [3:0]  m    [3];
   logic [31:0] rd   [3];
   logic        rdy  [3];
   logic        err  [3];
   logic        bsy  [3];
   logic [1:0]  st   [3];

   int ws_tab [3] = '{1, 0, 3};

   int checks   = 0;
   int failures = 0;

   logic [32:0] exp_q [$];

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  m;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   vec_t vtab [16];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WSV = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
      dmem_responder #(
         .DEPTH_WORDS(256),
         .WAIT_STATES(WSV),
         .BASE_ADDR  (32'h0000_1000)
      ) u_dut (
         .clk      (clk),
         .reset    (rst[g]),
         .mem_req  (req[g]),
         .mem_we   (we[g]),
         .mem_a    (a[g]),
         .mem_wd   (wd[g]),
         .mem_wmask(m[g]),
         .mem_rd   (rd[g]),
         .mem_ready(rdy[g]),
         .mem_err  (err[g]),
         .busy     (bsy[g]),
         .dbg_state(st[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one access on build k, wait (bounded) for mem_ready and compare with the scoreboard.
   task automatic access(input int k, input logic w, input logic [31:0] ad, input logic [31:0] d,
                         input logic [3:0] mk, input logic [32:0] exp, input bit perturb);
      int          n;
      int          bcnt;
      bit          seen;
      bit          stray;
      logic [31:0] rd_s;
      logic        err_s;
      logic [32:0] e;
      @(negedge clk);
      chk("busy_idle", {32'h0, bsy[k]}, 33'h0);
      req[k] = 1'b1;
      we[k]  = w;
      a[k]   = ad;
      wd[k]  = d;
      m[k]   = mk;
      exp_q.push_back(exp);
      n = 0; bcnt = 0; seen = 0; stray = 0; rd_s = 32'h0; err_s = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (perturb && n == 1) begin
            req[k] = 1'b0;
            we[k]  = ~w;
            a[k]   = ad ^ 32'h4;
            wd[k]  = ~d;
            m[k]   = ~mk;
         end
         if (bsy[k]) bcnt++;
         if (err[k] && !rdy[k]) stray = 1;
         if (rdy[k]) begin
            seen  = 1;
            rd_s  = rd[k];
            err_s = err[k];
         end
      end
      req[k] = 1'b0;
      e = exp_q.pop_front();
      if (!seen) begin
         chk("ready_timeout", 33'h1, 33'h0);
      end else begin
         chk("latency", 33'(n), 33'(ws_tab[k] + 1));
         chk("busy_cycles", 33'(bcnt), 33'(ws_tab[k] + 1));
         chk("rd", {1'b0, rd_s}, {1'b0, e[31:0]});
         chk("err", {32'h0, err_s}, {32'h0, e[32]});
         chk("err_outside_resp", {32'h0, stray}, 33'h0);
         @(negedge clk);
         chk("ready_pulse_end", {31'h0, rdy[k], bsy[k]}, 33'h0);
      end
   endtask

   initial begin
      logic [31:0] last_rd;
      logic [31:0] mdl;
      logic [31:0] d1, d2, addr;
      logic [3:0]  mk;
      int          idx;

      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0;
         a[k] = 32'h0; wd[k] = 32'h0; m[k] = 4'h0;
      end
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("reset_rd", {1'b0, rd[k]}, 33'h0);
         chk("reset_flags", {29'h0, rdy[k], err[k], bsy[k], st[k] != 2'd0}, 33'h0);
         rst[k] = 1'b0;
      end

      vtab[0]  = '{1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
      vtab[1]  = '{1'b0, 32'h0000_1010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
      vtab[2]  = '{1'b1, 32'h0000_1020, 32'h1122_3344, 4'hF, 32'hDEAD_BEEF, 1'b0};
      vtab[3]  = '{1'b1, 32'h0000_1020, 32'h0000_AA00, 4'h2, 32'hDEAD_BEEF, 1'b0};
      vtab[4]  = '{1'b0, 32'h0000_1022, 32'h0000_0000, 4'h0, 32'h1122_AA44, 1'b0};
      vtab[5]  = '{1'b1, 32'h0000_1020, 32'hFFFF_FFFF, 4'h0, 32'h1122_AA44, 1'b0};
      vtab[6]  = '{1'b0, 32'h0000_1020, 32'h0000_0000, 4'h0, 32'h1122_AA44, 1'b0};
      vtab[7]  = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'h1122_AA44, 1'b0};
      vtab[8]  = '{1'b0, 32'h0000_1400, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
      vtab[9]  = '{1'b1, 32'h0000_1400, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1};
      vtab[10] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};
      vtab[11] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
      vtab[12] = '{1'b1, 32'h0000_13FC, 32'h0102_0304, 4'hF, 32'h0000_0000, 1'b0};
      vtab[13] = '{1'b1, 32'h0000_13FC, 32'hA5A5_A5A5, 4'h9, 32'h0000_0000, 1'b0};
      vtab[14] = '{1'b0, 32'h0000_13FF, 32'h0000_0000, 4'h0, 32'hA502_03A5, 1'b0};
      vtab[15] = '{1'b0, 32'h0000_1010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};

      for (int i = 0; i < 16; i++) begin
         access(0, vtab[i].we, vtab[i].a, vtab[i].wd, vtab[i].m, {vtab[i].err, vtab[i].rd}, 1'b0);
      end
      last_rd = 32'hDEAD_BEEF;

      // Random full writes, random-lane overwrites, then read back against a lane model.
      for (int it = 0; it < 6; it++) begin
         idx  = $urandom_range(64, 127);
         addr = 32'h0000_1000 + (32'(idx) << 2);
         d1   = $urandom;
         d2   = $urandom;
         mk   = 4'($urandom_range(0, 15));
         access(0, 1'b1, addr, d1, 4'hF, {1'b0, last_rd}, 1'b0);
         mdl = d1;
         for (int b = 0; b < 4; b++) begin
            if (mk[b]) mdl[8*b +: 8] = d2[8*b +: 8];
         end
         access(0, 1'b1, addr, d2, mk, {1'b0, last_rd}, 1'b0);
         access(0, 1'b0, addr, 32'h0, 4'h0, {1'b0, mdl}, 1'b0);
         last_rd = mdl;
      end

      // mem_req held high: back-to-back reads complete every third cycle with one wait state.
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b0; a[0] = 32'h0000_1010;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         chk($sformatf("held_req_ready_c%0d", e), {32'h0, rdy[0]},
             {32'h0, (e == 2 || e == 5 || e == 8)});
         if (rdy[0]) chk("held_req_rd", {1'b0, rd[0]}, {1'b0, 32'hDEAD_BEEF});
      end
      req[0] = 1'b0;
      @(negedge clk);

      // Zero-wait-state build.
      access(1, 1'b1, 32'h0000_1000, 32'h600D_CAFE, 4'hF, {1'b0, 32'h0}, 1'b0);
      access(1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, {1'b0, 32'h600D_CAFE}, 1'b0);
      access(1, 1'b0, 32'h0000_1400, 32'h0, 4'h0, {1'b1, 32'h0}, 1'b0);

      // Three-wait-state build: inputs scrambled and mem_req dropped during WAIT.
      access(2, 1'b1, 32'h0000_1044, 32'h0BAD_F00D, 4'hF, {1'b0, 32'h0}, 1'b0);
      access(2, 1'b1, 32'h0000_1040, 32'h55AA_55AA, 4'hF, {1'b0, 32'h0}, 1'b1);
      access(2, 1'b0, 32'h0000_1040, 32'h0, 4'h0, {1'b0, 32'h55AA_55AA}, 1'b0);
      access(2, 1'b0, 32'h0000_1044, 32'h0, 4'h0, {1'b0, 32'h0BAD_F00D}, 1'b0);

      // Reset asserted during WAIT of a write aborts it without touching the array.
      access(2, 1'b1, 32'h0000_1080, 32'h1357_9BDF, 4'hF, {1'b0, 32'h0BAD_F00D}, 1'b0);
      access(2, 1'b0, 32'h0000_1080, 32'h0, 4'h0, {1'b0, 32'h1357_9BDF}, 1'b0);
      @(negedge clk);
      req[2] = 1'b1; we[2] = 1'b1; a[2] = 32'h0000_1080; wd[2] = 32'hFFFF_FFFF; m[2] = 4'hF;
      @(negedge clk);
      chk("busy_before_reset", {32'h0, bsy[2]}, 33'h1);
      req[2] = 1'b0;
      rst[2] = 1'b1;
      #1;
      chk("abort_rd", {1'b0, rd[2]}, 33'h0);
      chk("abort_flags", {29'h0, rdy[2], err[2], bsy[2], st[2] != 2'd0}, 33'h0);
      @(negedge clk);
      rst[2] = 1'b0;
      access(2, 1'b0, 32'h0000_1080, 32'h0, 4'h0, {1'b0, 32'h1357_9BDF}, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
